// File: rtl/solver_dispatch.sv
// solver_dispatch: accepts a job header and its limb stream, then programs and launches the
// solver core and returns the solver's iteration count tagged with the job's pixel id.
//
// Ports:
//   clock, reset                  clock and synchronous active-high reset
//   i_job_valid/o_job_ready       job header handshake (num_limbs, iter_lim, tag)
//   i_limb_valid/o_limb_ready     limb stream: real limbs 0..N, then imaginary limbs 0..N
//   o_wr_real_en/o_wr_imag_en     per-limb write strobes, index on o_wr_ind, data on o_c_wdata
//   o_wr_num_limbs_en/..._data    configuration writes to the solver
//   o_wr_iter_lim_en/..._data
//   o_start                       one-cycle solve launch pulse
//   i_out_ready/i_iteration_count solver done flag and result
//   o_res_valid/i_res_ready       result handshake carrying o_res_tag and o_res_count
//   o_busy                        high whenever a job is in flight
module solver_dispatch #(
   parameter int unsigned LIMB_INDEX_BITS = 6,
   parameter int unsigned LIMB_BITS       = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       i_job_valid,
   output logic                       o_job_ready,
   input  logic [LIMB_INDEX_BITS-1:0] i_job_num_limbs,
   input  logic [15:0]                i_job_iter_lim,
   input  logic [15:0]                i_job_tag,
   input  logic                       i_limb_valid,
   output logic                       o_limb_ready,
   input  logic [LIMB_BITS-1:0]       i_limb_data,
   output logic                       o_wr_real_en,
   output logic                       o_wr_imag_en,
   output logic [LIMB_INDEX_BITS-1:0] o_wr_ind,
   output logic [LIMB_BITS-1:0]       o_c_wdata,
   output logic                       o_wr_num_limbs_en,
   output logic [LIMB_INDEX_BITS-1:0] o_num_limbs_data,
   output logic                       o_wr_iter_lim_en,
   output logic [15:0]                o_iter_lim_data,
   output logic                       o_start,
   input  logic                       i_out_ready,
   input  logic [15:0]                i_iteration_count,
   output logic                       o_res_valid,
   input  logic                       i_res_ready,
   output logic [15:0]                o_res_tag,
   output logic [15:0]                o_res_count,
   output logic                       o_busy
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CFG     = 3'd1;
   localparam logic [2:0] S_LOAD_RE = 3'd2;
   localparam logic [2:0] S_LOAD_IM = 3'd3;
   localparam logic [2:0] S_START   = 3'd4;
   localparam logic [2:0] S_SETTLE  = 3'd5;
   localparam logic [2:0] S_RUN     = 3'd6;
   localparam logic [2:0] S_RESULT  = 3'd7;

   logic [2:0]                 r_state;
   logic [LIMB_INDEX_BITS-1:0] r_count;
   logic [LIMB_INDEX_BITS-1:0] r_num_limbs;
   logic [15:0]                r_iter_lim;
   logic [15:0]                r_tag;
   logic [15:0]                r_res_count;

   logic [2:0]                 w_state_next;
   logic [LIMB_INDEX_BITS-1:0] w_count_next;
   logic                       w_loading;
   logic                       w_limb_acc;
   logic                       w_last;
   logic                       w_job_acc;
   logic                       w_done;

   assign w_loading  = (r_state == S_LOAD_RE) || (r_state == S_LOAD_IM);
   assign w_limb_acc = i_limb_valid && w_loading;
   assign w_last     = (r_count == r_num_limbs);
   assign w_job_acc  = (r_state == S_IDLE) && i_job_valid;
   assign w_done     = (r_state == S_RUN) && i_out_ready;

   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      case (r_state)
         S_IDLE:    if (i_job_valid) w_state_next = S_CFG;
         S_CFG: begin
            w_count_next = '0;
            w_state_next = S_LOAD_RE;
         end
         S_LOAD_RE, S_LOAD_IM: begin
            if (w_limb_acc) begin
               if (w_last) begin
                  w_count_next = '0;
                  w_state_next = (r_state == S_LOAD_RE) ? S_LOAD_IM : S_START;
               end else begin
                  w_count_next = r_count + 1'b1;
               end
            end
         end
         S_START:   w_state_next = S_SETTLE;
         // The solver still shows its stale idle flag here, so it is not looked at.
         S_SETTLE:  w_state_next = S_RUN;
         S_RUN:     if (i_out_ready) w_state_next = S_RESULT;
         S_RESULT:  if (i_res_ready) w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_num_limbs <= '0;
         r_iter_lim  <= '0;
         r_tag       <= '0;
         r_res_count <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         if (w_job_acc) begin
            r_num_limbs <= i_job_num_limbs;
            // A zero limit would never let the solver iterate; run at least once.
            r_iter_lim  <= (i_job_iter_lim == 16'd0) ? 16'd1 : i_job_iter_lim;
            r_tag       <= i_job_tag;
         end
         if (w_done) r_res_count <= i_iteration_count;
      end
   end

   assign o_job_ready       = (r_state == S_IDLE);
   assign o_limb_ready      = w_loading;
   assign o_wr_real_en      = (r_state == S_LOAD_RE) && i_limb_valid;
   assign o_wr_imag_en      = (r_state == S_LOAD_IM) && i_limb_valid;
   assign o_wr_ind          = r_count;
   assign o_c_wdata         = i_limb_data;
   assign o_wr_num_limbs_en = (r_state == S_CFG);
   assign o_wr_iter_lim_en  = (r_state == S_CFG);
   assign o_num_limbs_data  = r_num_limbs;
   assign o_iter_lim_data   = r_iter_lim;
   assign o_start           = (r_state == S_START);
   assign o_res_valid       = (r_state == S_RESULT);
   assign o_res_tag         = r_tag;
   assign o_res_count       = r_res_count;
   assign o_busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_solver_dispatch.sv
module tb_solver_dispatch;

   localparam int IB = 6;
   localparam int LB = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          i_job_valid;
   logic          o_job_ready;
   logic [IB-1:0] i_job_num_limbs;
   logic [15:0]   i_job_iter_lim;
   logic [15:0]   i_job_tag;
   logic          i_limb_valid;
   logic          o_limb_ready;
   logic [LB-1:0] i_limb_data;
   logic          o_wr_real_en;
   logic          o_wr_imag_en;
   logic [IB-1:0] o_wr_ind;
   logic [LB-1:0] o_c_wdata;
   logic          o_wr_num_limbs_en;
   logic [IB-1:0] o_num_limbs_data;
   logic          o_wr_iter_lim_en;
   logic [15:0]   o_iter_lim_data;
   logic          o_start;
   logic          i_out_ready;
   logic [15:0]   i_iteration_count;
   logic          o_res_valid;
   logic          i_res_ready;
   logic [15:0]   o_res_tag;
   logic [15:0]   o_res_count;
   logic          o_busy;

   int checks = 0;
   int errors = 0;

   solver_dispatch #(
      .LIMB_INDEX_BITS (IB),
      .LIMB_BITS       (LB)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .i_job_valid       (i_job_valid),
      .o_job_ready       (o_job_ready),
      .i_job_num_limbs   (i_job_num_limbs),
      .i_job_iter_lim    (i_job_iter_lim),
      .i_job_tag         (i_job_tag),
      .i_limb_valid      (i_limb_valid),
      .o_limb_ready      (o_limb_ready),
      .i_limb_data       (i_limb_data),
      .o_wr_real_en      (o_wr_real_en),
      .o_wr_imag_en      (o_wr_imag_en),
      .o_wr_ind          (o_wr_ind),
      .o_c_wdata         (o_c_wdata),
      .o_wr_num_limbs_en (o_wr_num_limbs_en),
      .o_num_limbs_data  (o_num_limbs_data),
      .o_wr_iter_lim_en  (o_wr_iter_lim_en),
      .o_iter_lim_data   (o_iter_lim_data),
      .o_start           (o_start),
      .i_out_ready       (i_out_ready),
      .i_iteration_count (i_iteration_count),
      .o_res_valid       (o_res_valid),
      .i_res_ready       (i_res_ready),
      .o_res_tag         (o_res_tag),
      .o_res_count       (o_res_count),
      .o_busy            (o_busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_excl();
      chk("strobe_exclusive",
          32'($countones({o_wr_real_en, o_wr_imag_en, o_wr_num_limbs_en, o_start}) <= 1), 1);
   endtask

   task automatic chk_idle(input string where);
      chk({where, "_job_ready"}, o_job_ready, 1);
      chk({where, "_busy"}, o_busy, 0);
      chk({where, "_res_valid"}, o_res_valid, 0);
      chk({where, "_limb_ready"}, o_limb_ready, 0);
      chk({where, "_strobes"},
          {o_wr_real_en, o_wr_imag_en, o_wr_num_limbs_en, o_wr_iter_lim_en, o_start}, 0);
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b1;
      i_limb_valid = 1'b0;
      i_job_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk_idle("after_reset");
      chk("after_reset_res_tag", o_res_tag, 0);
      chk("after_reset_res_count", o_res_count, 0);
   endtask

   // One job end to end. gap_at: limb index before which limb_valid drops for gap_len
   // cycles. abort: 0 none, 1 reset at gap_at during the load, 2 reset in RUN.
   task automatic do_job(input int n, input int lim, input logic [15:0] tag,
                         input int gap_at, input int gap_len, input bit early_high,
                         input int run_delay, input logic [15:0] cnt, input int hold,
                         input int abort);
      int          cyc;
      int          exp_cyc;
      int          nl;
      logic [31:0] d;
      nl = 2 * (n + 1);
      exp_cyc = nl + 2 + ((gap_at < nl) ? gap_len : 0);

      @(negedge clock);
      i_out_ready     = 1'b1;
      i_res_ready     = 1'b0;
      i_limb_valid    = 1'b0;
      i_job_valid     = 1'b1;
      i_job_num_limbs = IB'(n);
      i_job_iter_lim  = 16'(lim);
      i_job_tag       = tag;
      #1;
      chk("idle_job_ready", o_job_ready, 1);
      chk("idle_busy", o_busy, 0);

      @(negedge clock);
      i_job_valid     = 1'b0;
      i_job_num_limbs = IB'($urandom);
      i_job_iter_lim  = 16'($urandom);
      i_job_tag       = 16'($urandom);
      cyc = 1;
      #1;
      chk("cfg_wr_num_limbs_en", o_wr_num_limbs_en, 1);
      chk("cfg_wr_iter_lim_en", o_wr_iter_lim_en, 1);
      chk("cfg_num_limbs_data", o_num_limbs_data, n);
      chk("cfg_iter_lim_data", o_iter_lim_data, (lim == 0) ? 1 : lim);
      chk("cfg_limb_ready", o_limb_ready, 0);
      chk("cfg_busy", o_busy, 1);
      chk_excl();

      for (int k = 0; k < nl; k++) begin
         if (k == gap_at) begin
            if (abort == 1) begin
               pulse_reset();
               return;
            end
            for (int g = 0; g < gap_len; g++) begin
               @(negedge clock);
               cyc++;
               i_limb_valid = 1'b0;
               i_limb_data  = $urandom;
               #1;
               chk("gap_wr_real_en", o_wr_real_en, 0);
               chk("gap_wr_imag_en", o_wr_imag_en, 0);
               chk("gap_limb_ready", o_limb_ready, 1);
            end
         end
         @(negedge clock);
         cyc++;
         d = $urandom;
         i_limb_valid = 1'b1;
         i_limb_data  = d;
         #1;
         chk("load_limb_ready", o_limb_ready, 1);
         chk("load_wr_real_en", o_wr_real_en, (k <= n) ? 1 : 0);
         chk("load_wr_imag_en", o_wr_imag_en, (k > n) ? 1 : 0);
         chk("load_wr_ind", o_wr_ind, k % (n + 1));
         chk("load_c_wdata", o_c_wdata, d);
         chk_excl();
      end

      @(negedge clock);
      cyc++;
      i_limb_valid = 1'b0;
      #1;
      chk("start_pulse", o_start, 1);
      chk("start_latency", cyc, exp_cyc);
      chk("start_limb_ready", o_limb_ready, 0);
      chk_excl();

      @(negedge clock);
      i_out_ready       = early_high;
      i_iteration_count = 16'($urandom);
      #1;
      chk("settle_start_low", o_start, 0);
      chk("settle_res_valid", o_res_valid, 0);

      for (int r = 0; r < run_delay; r++) begin
         @(negedge clock);
         i_out_ready       = 1'b0;
         i_iteration_count = 16'($urandom);
         #1;
         chk("run_res_valid", o_res_valid, 0);
         chk("run_busy", o_busy, 1);
         if (abort == 2) begin
            pulse_reset();
            return;
         end
      end

      @(negedge clock);
      i_out_ready       = 1'b1;
      i_iteration_count = cnt;
      #1;
      chk("done_res_valid", o_res_valid, 0);

      @(negedge clock);
      i_iteration_count = 16'($urandom);
      for (int h = 0; h <= hold; h++) begin
         if (h > 0) @(negedge clock);
         i_res_ready = (h == hold);
         #1;
         chk("res_valid", o_res_valid, 1);
         chk("res_tag", o_res_tag, tag);
         chk("res_count", o_res_count, cnt);
         chk("res_job_ready", o_job_ready, 0);
      end

      @(negedge clock);
      i_res_ready = 1'b0;
      #1;
      chk("post_job_ready", o_job_ready, 1);
      chk("post_res_valid", o_res_valid, 0);
      chk("post_busy", o_busy, 0);
   endtask

   initial begin
      reset             = 1'b1;
      i_job_valid       = 1'b0;
      i_job_num_limbs   = '0;
      i_job_iter_lim    = '0;
      i_job_tag         = '0;
      i_limb_valid      = 1'b0;
      i_limb_data       = '0;
      i_out_ready       = 1'b1;
      i_iteration_count = '0;
      i_res_ready       = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      chk_idle("reset");
      chk("reset_res_tag", o_res_tag, 0);
      chk("reset_res_count", o_res_count, 0);
      reset = 1'b0;

      do_job(2, 100, 16'h0012, 99, 0, 1'b0, 3, 16'd37, 0, 0);
      do_job(2, 100, 16'h0012, 2, 3, 1'b0, 3, 16'd37, 0, 0);
      do_job(1, 0, 16'h0055, 99, 0, 1'b0, 2, 16'($urandom), 0, 0);
      do_job(3, 500, 16'hbeef, 99, 0, 1'b0, 1, 16'($urandom), 10, 0);
      do_job(2, 100, 16'h0077, 99, 0, 1'b0, 3, 16'd5, 0, 2);
      do_job(2, 100, 16'h0078, 99, 0, 1'b0, 2, 16'd6, 0, 0);
      do_job(0, 7, 16'h0001, 99, 0, 1'b1, 2, 16'($urandom), 1, 0);
      do_job(4, 9, 16'h0abc, 1, 0, 1'b0, 2, 16'd1, 0, 1);
      do_job(1, 9, 16'h0abd, 99, 0, 1'b0, 0, 16'd2, 0, 0);

      for (int j = 0; j < 12; j++) begin
         int n;
         n = int'($urandom_range(0, 5));
         do_job(n, int'($urandom_range(0, 3)) * int'($urandom_range(0, 300)),
                16'($urandom), int'($urandom_range(0, 2 * (n + 1) + 2)),
                int'($urandom_range(1, 4)), 1'($urandom), int'($urandom_range(1, 6)),
                16'($urandom), int'($urandom_range(0, 3)), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
